// File: rtl/usart_frame_arbiter_pkg.sv
// usart_frame_arbiter_pkg: frame FSM states, channel IDs and default header byte
package usart_frame_arbiter_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ID, S_LEN, S_DATA, S_CSUM, S_GAP} state_t;
  localparam logic [7:0] CH0_ID = 8'h00;
  localparam logic [7:0] CH1_ID = 8'h01;
  localparam logic [7:0] DEF_HEADER = 8'h44;
endpackage

// File: rtl/usart_frame_arbiter_if.sv
// usart_frame_arbiter_if: byte handshake towards the USART transmitter
interface usart_frame_arbiter_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/usart_rr_arb2.sv
// usart_rr_arb2: two-request round-robin picker; pointer moves past every winner
module usart_rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  input  logic i_advance,
  output logic o_winner,
  output logic o_valid,
  output logic o_ptr_nxt
);
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_winner = (i_req0 & i_req1) ? i_ptr : i_req1;
    o_ptr_nxt = (i_advance & o_valid) ? ~o_winner : i_ptr;
  end
endmodule

// File: rtl/usart_frame_arbiter.sv
// usart_frame_arbiter: round-robin framing of two result producers onto one USART TX
// Define USART_FRAME_CHECKSUM_EN to append a mod-256 checksum byte after the payload
module usart_frame_arbiter
  import usart_frame_arbiter_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 8,
  parameter int GAP_CYCLES = 25000000,
  parameter logic [7:0] HEADER_BYTE = DEF_HEADER
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic [8*PAYLOAD_BYTES-1:0] i_payload0,
  output logic o_ack0,
  input  logic i_req1,
  input  logic [8*PAYLOAD_BYTES-1:0] i_payload1,
  output logic o_ack1,
  usart_frame_arbiter_if.master tx,
  output logic o_busy,
  output logic o_grant_id
);
  localparam int W = 8*PAYLOAD_BYTES;
  localparam logic [7:0] LEN = 8'(PAYLOAD_BYTES);
  localparam logic [7:0] LAST = 8'(PAYLOAD_BYTES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  state_t r_state, w_state;
  logic [W-1:0] r_sr, w_sr;
  logic [7:0] r_idx, w_idx, r_txd, w_txd;
  logic [31:0] r_gap, w_gap;
  logic r_ptr, w_ptr, r_ack0, w_ack0, r_ack1, w_ack1;
  logic r_busy, w_busy, r_gid, w_gid, r_txv, w_txv;
  logic w_win, w_req, w_xfer, w_done;
`ifdef USART_FRAME_CHECKSUM_EN
  logic [7:0] r_csum, w_csum;
`endif
  usart_rr_arb2 u_arb (
    .i_req0(i_req0),
    .i_req1(i_req1),
    .i_ptr(r_ptr),
    .i_advance(r_state == S_IDLE),
    .o_winner(w_win),
    .o_valid(w_req),
    .o_ptr_nxt(w_ptr)
  );
  assign w_xfer = r_txv & tx.tx_ready;
  always_comb begin
    w_state = r_state;
    w_sr = r_sr;
    w_idx = r_idx;
    w_txd = r_txd;
    w_gap = r_gap;
    w_busy = r_busy;
    w_gid = r_gid;
    w_txv = r_txv;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
`ifdef USART_FRAME_CHECKSUM_EN
    w_csum = (w_xfer && r_state inside {S_ID, S_LEN, S_DATA}) ? r_csum + r_txd : r_csum;
    w_done = w_xfer && r_state == S_CSUM;
`else
    w_done = w_xfer && r_state == S_DATA && r_idx == LAST;
`endif
    case (r_state)
      S_IDLE: if (w_req) begin
        w_ack0 = ~w_win;
        w_ack1 = w_win;
        w_sr = w_win ? i_payload1 : i_payload0;
        w_gid = w_win;
        w_busy = 1'b1;
        w_txv = 1'b1;
        w_txd = HEADER_BYTE;
        w_idx = '0;
        w_state = S_HDR;
`ifdef USART_FRAME_CHECKSUM_EN
        w_csum = '0;
`endif
      end
      S_HDR: if (w_xfer) begin
        w_txd = r_gid ? CH1_ID : CH0_ID;
        w_state = S_ID;
      end
      S_ID: if (w_xfer) begin
        w_txd = LEN;
        w_state = S_LEN;
      end
      S_LEN, S_DATA: if (w_xfer) begin
        if (r_state == S_LEN || r_idx != LAST) begin
          w_txd = r_sr[W-1 -: 8];
          w_sr = r_sr << 8;
          w_idx = (r_state == S_DATA) ? r_idx + 8'd1 : r_idx;
          w_state = S_DATA;
        end
`ifdef USART_FRAME_CHECKSUM_EN
        else begin
          w_txd = r_csum + r_txd;
          w_state = S_CSUM;
        end
`endif
      end
      S_GAP: begin
        w_gap = r_gap + 32'd1;
        if (r_gap == GAP_LAST) begin
          w_gap = '0;
          w_busy = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: ;
    endcase
    if (w_done) begin
      w_txv = 1'b0;
      w_busy = GAP_CYCLES != 0;
      w_state = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr <= '0;
      r_idx <= '0;
      r_txd <= '0;
      r_gap <= '0;
      r_ptr <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_busy <= 1'b0;
      r_gid <= 1'b0;
      r_txv <= 1'b0;
`ifdef USART_FRAME_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_sr <= w_sr;
      r_idx <= w_idx;
      r_txd <= w_txd;
      r_gap <= w_gap;
      r_ptr <= w_ptr;
      r_ack0 <= w_ack0;
      r_ack1 <= w_ack1;
      r_busy <= w_busy;
      r_gid <= w_gid;
      r_txv <= w_txv;
`ifdef USART_FRAME_CHECKSUM_EN
      r_csum <= w_csum;
`endif
    end
  end
  assign o_ack0 = r_ack0;
  assign o_ack1 = r_ack1;
  assign o_busy = r_busy;
  assign o_grant_id = r_gid;
  assign tx.tx_data = r_txd;
  assign tx.tx_valid = r_txv;
endmodule

// File: tb/tb_usart_frame_arbiter.sv
// tb_usart_frame_arbiter: directed frames, arbitration order, stalls, reset abort, zero gap
module tb_usart_frame_arbiter;
`ifdef USART_FRAME_CHECKSUM_EN
  localparam int FL = 12;
`else
  localparam int FL = 11;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic a_req0 = 1'b0, a_req1 = 1'b0, b_req1 = 1'b0;
  logic [63:0] a_p0 = '0, a_p1 = '0, b_p = 64'h1111_2222_3333_4444;
  logic [63:0] zero64 = '0;
  logic zero1 = 1'b0;
  logic a_ack0, a_ack1, a_busy, a_gid, b_ack0, b_ack1, b_busy, b_gid;
  int checks = 0, errors = 0, a_n0 = 0;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  usart_frame_arbiter_if a_if ();
  usart_frame_arbiter_if b_if ();
  usart_frame_arbiter #(.PAYLOAD_BYTES(8), .GAP_CYCLES(4)) u_a (
    .clk(clk), .rst(rst),
    .i_req0(a_req0), .i_payload0(a_p0), .o_ack0(a_ack0),
    .i_req1(a_req1), .i_payload1(a_p1), .o_ack1(a_ack1),
    .tx(a_if), .o_busy(a_busy), .o_grant_id(a_gid)
  );
  usart_frame_arbiter #(.PAYLOAD_BYTES(8), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst),
    .i_req0(zero1), .i_payload0(zero64), .o_ack0(b_ack0),
    .i_req1(b_req1), .i_payload1(b_p), .o_ack1(b_ack1),
    .tx(b_if), .o_busy(b_busy), .o_grant_id(b_gid)
  );
  always @(posedge clk) begin
    if (a_if.tx_valid && a_if.tx_ready) a_q.push_back(a_if.tx_data);
    if (b_if.tx_valid && b_if.tx_ready) b_q.push_back(b_if.tx_data);
  end
  always @(negedge clk) if (a_ack0) a_n0++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_frame(input string tag, input logic [7:0] id, input logic [63:0] p);
    logic [7:0] e[$];
    logic [7:0] b;
`ifdef USART_FRAME_CHECKSUM_EN
    logic [7:0] s;
`endif
    e = {8'h44, id, 8'h08};
    for (int i = 7; i >= 0; i--) e.push_back(p[8*i +: 8]);
`ifdef USART_FRAME_CHECKSUM_EN
    s = 8'h00;
    for (int i = 1; i < e.size(); i++) s += e[i];
    e.push_back(s);
`endif
    chk({tag, "_avail"}, a_q.size() >= e.size(), 1'b1);
    foreach (e[i]) begin
      b = 'x;
      if (a_q.size() != 0) b = a_q.pop_front();
      chk($sformatf("%s_b%0d", tag, i), b, e[i]);
    end
  endtask
  task automatic wait_ack(input logic ch, input string tag);
    int n = 0;
    while (!(ch ? a_ack1 : a_ack0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, n < 100, 1'b1);
    chk({tag, "_gid"}, a_gid, ch);
    if (ch) a_req1 = 1'b0;
    else a_req0 = 1'b0;
  endtask
  task automatic wait_free(input string tag);
    int n = 0;
    while (a_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_free"}, a_busy, 1'b0);
  endtask
  initial begin
    int n, n0;
    a_if.tx_ready = 1'b1;
    b_if.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txv", a_if.tx_valid, 1'b0);
    chk("rst_txd", a_if.tx_data, 8'h00);
    chk("rst_ack", {a_ack0, a_ack1}, 2'b00);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_gid", a_gid, 1'b0);
    rst = 1'b0;
    a_p0 = 64'h0000_1234_0000_5678;
    a_p1 = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    a_req0 = 1'b1;
    @(negedge clk);
    chk("t1_ack0", a_ack0, 1'b1);
    chk("t1_hdr", a_if.tx_data, 8'h44);
    chk("t1_txv", a_if.tx_valid, 1'b1);
    chk("t1_busy", a_busy, 1'b1);
    a_req0 = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", a_ack0, 1'b0);
    repeat (FL + 2) @(negedge clk);
    chk("t1_busy_gap", a_busy, 1'b1);
    chk("t1_txv_gap", a_if.tx_valid, 1'b0);
    @(negedge clk);
    chk("t1_busy_end", a_busy, 1'b0);
    chk_frame("t1", 8'h00, a_p0);
    chk("t1_ack_cnt", a_n0, 1);
    rst = 1'b1;
    a_req0 = 1'b1;
    a_req1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(1'b0, "t2a");
    wait_ack(1'b1, "t2b");
    wait_free("t2");
    chk_frame("t2a", 8'h00, a_p0);
    chk_frame("t2b", 8'h01, a_p1);
    a_req0 = 1'b1;
    a_req1 = 1'b1;
    wait_ack(1'b0, "t2c");
    wait_ack(1'b1, "t2d");
    wait_free("t2x");
    chk_frame("t2c", 8'h00, a_p0);
    chk_frame("t2d", 8'h01, a_p1);
    a_req0 = 1'b1;
    a_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(i[0], $sformatf("alt%0d", i));
      if (i < 2) begin
        if (i[0]) a_req1 = 1'b1;
        else a_req0 = 1'b1;
      end
    end
    wait_free("alt");
    chk_frame("alt0", 8'h00, a_p0);
    chk_frame("alt1", 8'h01, a_p1);
    chk_frame("alt2", 8'h00, a_p0);
    chk_frame("alt3", 8'h01, a_p1);
    a_req0 = 1'b1;
    wait_ack(1'b0, "bp");
    repeat (5) @(negedge clk);
    chk("bp_pre", a_if.tx_data, 8'h12);
    a_if.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_d", a_if.tx_data, 8'h12);
      chk("bp_hold_v", a_if.tx_valid, 1'b1);
    end
    a_if.tx_ready = 1'b1;
    wait_free("bp");
    chk_frame("bp", 8'h00, a_p0);
    a_req0 = 1'b1;
    wait_ack(1'b0, "mr");
    repeat (6) @(negedge clk);
    chk("mr_b3", a_if.tx_data, 8'h34);
    n0 = a_n0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_txv", a_if.tx_valid, 1'b0);
    chk("mr_busy", a_busy, 1'b0);
    rst = 1'b0;
    a_q.delete();
    a_req1 = 1'b1;
    wait_ack(1'b1, "mr1");
    repeat (3) @(negedge clk);
    a_req0 = 1'b1;
    @(negedge clk);
    a_req0 = 1'b0;
    wait_free("wd");
    repeat (5) @(negedge clk);
    chk_frame("mr1", 8'h01, a_p1);
    chk("wd_q_empty", a_q.size(), 0);
    chk("wd_no_ack0", a_n0, n0);
    b_req1 = 1'b1;
    n = 0;
    while (!b_if.tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("zg_start", b_if.tx_valid, 1'b1);
    n = 0;
    while (b_if.tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("zg_frame_cycles", n, FL);
    n = 0;
    while (!b_if.tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("zg_gap_cycles", n, 1);
    b_req1 = 1'b0;
    n = 0;
    while (b_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("zg_free", b_busy, 1'b0);
    chk("zg_count", b_q.size(), 2 * FL);
    chk("zg_hdr2", b_q.size() > FL ? b_q[FL] : 8'hxx, 8'h44);
    chk("zg_id2", b_q.size() > FL + 1 ? b_q[FL+1] : 8'hxx, 8'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
